// File: rtl/seg7_scan_to_bcd_if.sv
// Multiplexed 7-segment display bus plus the reconstructed-digit readback signals.
// The display driver side is the master; the scan-to-BCD observer is the slave.
interface seg7_scan_to_bcd_if;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic [15:0] DIGITS;
    logic [3:0]  VALID;
    logic [3:0]  ERR;
    logic        UPDATE;
    logic [1:0]  DIGIT_IDX;

    modport master (
        output SEG, AN,
        input  DIGITS, VALID, ERR, UPDATE, DIGIT_IDX
    );

    modport slave (
        input  SEG, AN,
        output DIGITS, VALID, ERR, UPDATE, DIGIT_IDX
    );
endinterface

// File: rtl/seg7_scan_to_bcd.sv
// Watches a 4-digit multiplexed 7-segment bus and rebuilds the BCD value on each digit,
// capturing a digit only after its {AN, SEG} pattern has been stable for STABLE_CNT cycles.
module seg7_scan_to_bcd #(
    parameter int STABLE_CNT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    seg7_scan_to_bcd_if.slave bus
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CNT - 1);

    // Returns {legal, value}; only the canonical glyphs are accepted.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h3F:   return {1'b1, 4'd0};
            7'h06:   return {1'b1, 4'd1};
            7'h5B:   return {1'b1, 4'd2};
            7'h4F:   return {1'b1, 4'd3};
            7'h66:   return {1'b1, 4'd4};
            7'h6D:   return {1'b1, 4'd5};
            7'h7D:   return {1'b1, 4'd6};
            7'h07:   return {1'b1, 4'd7};
            7'h7F:   return {1'b1, 4'd8};
            7'h6F:   return {1'b1, 4'd9};
            default: return {1'b0, 4'hF};
        endcase
    endfunction

    logic [10:0]   s_q,         s_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [15:0]   digits_q,    digits_d;
    logic [3:0]    valid_q,     valid_d;
    logic [3:0]    err_q,       err_d;
    logic          update_q,    update_d;
    logic [1:0]    digit_idx_q, digit_idx_d;

    logic [10:0] sample;
    logic        onehot;
    logic        same;
    logic        capture;
    logic [1:0]  an_idx;
    logic [4:0]  dec;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        an_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.AN[i]) an_idx = 2'(i);
        end
    end

    always_comb begin
        sample  = {bus.AN, bus.SEG};
        onehot  = (bus.AN != 4'b0000) && ((bus.AN & (bus.AN - 4'd1)) == 4'b0000);
        same    = (sample == s_q);
        capture = onehot && same && (cnt_q == CNT_CAP);
        dec     = decode_seg(bus.SEG);

        s_d         = sample;
        cnt_d       = '0;
        digits_d    = digits_q;
        valid_d     = valid_q;
        err_d       = err_q;
        update_d    = capture;
        digit_idx_d = digit_idx_q;

        if (onehot && same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end else if (onehot) begin
            cnt_d = CW'(1);
        end

        if (capture) begin
            digit_idx_d             = an_idx;
            digits_d[4*an_idx +: 4] = dec[3:0];
            valid_d[an_idx]         = dec[4];
            // Blank digits are neither valid nor an error.
            err_d[an_idx]           = !dec[4] && (bus.SEG != 7'h00);
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!RST_N) begin
            s_q         <= '0;
            cnt_q       <= '0;
            digits_q    <= 16'hFFFF;
            valid_q     <= 4'b0000;
            err_q       <= 4'b0000;
            update_q    <= 1'b0;
            digit_idx_q <= 2'd0;
        end else begin
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            update_q    <= update_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign bus.DIGITS    = digits_q;
    assign bus.VALID     = valid_q;
    assign bus.ERR       = err_q;
    assign bus.UPDATE    = update_q;
    assign bus.DIGIT_IDX = digit_idx_q;

endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
// Bench for seg7_scan_to_bcd: hand-computed vector table, directed corner sequences,
// and random scanning checked every cycle against a history-based reference model.
module tb_seg7_scan_to_bcd;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_to_bcd_if bus ();

    seg7_scan_to_bcd #(.STABLE_CNT(S)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers recent inputs since reset; a capture happens on the edge
    // where exactly the last S samples are the same one-hot pattern.
    logic [6:0]  lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [10:0] hist [$];
    logic [15:0] m_digits = 16'hFFFF;
    logic [3:0]  m_valid = '0, m_err = '0;
    logic        m_upd = 1'b0;
    logic [1:0]  m_idx = '0;

    task automatic model_edge(input logic rst, input logic [10:0] v);
        int n, val, d;
        logic run_ok;
        m_upd = 1'b0;
        if (!rst) begin
            hist.delete();
            m_digits = 16'hFFFF; m_valid = '0; m_err = '0; m_idx = '0;
            return;
        end
        hist.push_back(v);
        if (hist.size() > S + 1) void'(hist.pop_front());
        n = hist.size();
        if ($countones(v[10:7]) == 1 && n >= S) begin
            run_ok = 1'b1;
            for (int k = 1; k < S; k++) if (hist[n-1-k] != v) run_ok = 1'b0;
            if (n > S && hist[n-1-S] == v) run_ok = 1'b0;
            if (run_ok) begin
                d = 0;
                for (int b = 0; b < 4; b++) if (v[7+b]) d = b;
                val = -1;
                for (int j = 0; j < 10; j++) if (lut[j] == v[6:0]) val = j;
                m_upd = 1'b1;
                m_idx = 2'(d);
                if (val >= 0) begin
                    m_digits[4*d +: 4] = 4'(val); m_valid[d] = 1'b1; m_err[d] = 1'b0;
                end else begin
                    m_digits[4*d +: 4] = 4'hF; m_valid[d] = 1'b0; m_err[d] = (v[6:0] != 7'h00);
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 ns later.
    task automatic step(input logic rst, input logic [3:0] an, input logic [6:0] seg);
        @(negedge clk);
        rst_n = rst; bus.AN = an; bus.SEG = seg;
        @(posedge clk);
        model_edge(rst, {an, seg});
        #1;
        check("model_digits", 32'(bus.DIGITS), 32'(m_digits));
        check("model_valid", 32'(bus.VALID), 32'(m_valid));
        check("model_err", 32'(bus.ERR), 32'(m_err));
        check("model_update", 32'(bus.UPDATE), 32'(m_upd));
        check("model_idx", 32'(bus.DIGIT_IDX), 32'(m_idx));
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  err;
        logic        upd;
        logic [1:0]  idx;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(input logic rst, input logic [3:0] an, input logic [6:0] seg,
                                input logic [15:0] digits, input logic [3:0] valid,
                                input logic upd, input int reps);
        for (int i = 0; i < reps; i++) vecs.push_back('{rst, an, seg, digits, valid, 4'h0, upd, 2'd0});
    endfunction

    int  upd_cnt;
    logic saw8;

    initial begin
        bus.AN = '0; bus.SEG = '0;

        // Reset, short run without capture, then a single long run of digit "2" on digit 0.
        add(1'b0, 4'b1111, 7'h7F, 16'hFFFF, 4'h0, 1'b0, 1);
        add(1'b0, 4'b0101, 7'h12, 16'hFFFF, 4'h0, 1'b0, 1);
        add(1'b1, 4'b0001, 7'h06, 16'hFFFF, 4'h0, 1'b0, 3);
        add(1'b1, 4'b0001, 7'h5B, 16'hFFFF, 4'h0, 1'b0, 3);
        add(1'b1, 4'b0001, 7'h5B, 16'hFFF2, 4'h1, 1'b1, 1);
        add(1'b1, 4'b0001, 7'h5B, 16'hFFF2, 4'h1, 1'b0, 10);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].an, vecs[i].seg);
            check($sformatf("tbl%0d_digits", i), 32'(bus.DIGITS), 32'(vecs[i].digits));
            check($sformatf("tbl%0d_valid", i), 32'(bus.VALID), 32'(vecs[i].valid));
            check($sformatf("tbl%0d_err", i), 32'(bus.ERR), 32'(vecs[i].err));
            check($sformatf("tbl%0d_update", i), 32'(bus.UPDATE), 32'(vecs[i].upd));
            check($sformatf("tbl%0d_idx", i), 32'(bus.DIGIT_IDX), 32'(vecs[i].idx));
        end

        // Glitch rejection on digit 2.
        upd_cnt = 0; saw8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b0100, (i == 3) ? 7'h7F : 7'h4F);
            upd_cnt += int'(bus.UPDATE);
            if (bus.DIGITS[11:8] == 4'h8) saw8 = 1'b1;
        end
        check("glitch_updates", 32'(upd_cnt), 32'd1);
        check("glitch_no8", 32'(saw8), 32'd0);
        check("glitch_nibble2", 32'(bus.DIGITS[11:8]), 32'h3);

        // Full scan with 8-cycle dwell and a 1-cycle blanking gap.
        upd_cnt = 0;
        for (int d = 3; d >= 0; d--) begin
            logic [6:0] segs [4];
            segs = '{7'h3F, 7'h7F, 7'h6F, 7'h06};
            for (int c = 0; c < 8; c++) begin
                step(1'b1, 4'(1 << d), segs[d]);
                upd_cnt += int'(bus.UPDATE);
            end
            step(1'b1, 4'b0000, 7'h00);
            upd_cnt += int'(bus.UPDATE);
        end
        check("scan_updates", 32'(upd_cnt), 32'd4);
        check("scan_digits", 32'(bus.DIGITS), 32'h1980);
        check("scan_valid", 32'(bus.VALID), 32'hF);
        check("scan_err", 32'(bus.ERR), 32'h0);

        // Illegal then blank pattern on digit 1.
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0010, 7'h49);
        check("illegal_nibble1", 32'(bus.DIGITS[7:4]), 32'hF);
        check("illegal_valid1", 32'(bus.VALID[1]), 32'd0);
        check("illegal_err1", 32'(bus.ERR[1]), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0010, 7'h00);
        check("blank_nibble1", 32'(bus.DIGITS[7:4]), 32'hF);
        check("blank_valid1", 32'(bus.VALID[1]), 32'd0);
        check("blank_err1", 32'(bus.ERR[1]), 32'd0);

        // Multi-hot AN never captures; reset mid-run restarts the dwell.
        upd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'b0011, 7'h3F);
            upd_cnt += int'(bus.UPDATE);
        end
        check("multihot_updates", 32'(upd_cnt), 32'd0);
        step(1'b1, 4'b0001, 7'h3F);
        step(1'b1, 4'b0001, 7'h3F);
        step(1'b0, 4'b0001, 7'h3F);
        check("midrst_digits", 32'(bus.DIGITS), 32'hFFFF);
        for (int e = 1; e <= 5; e++) begin
            step(1'b1, 4'b0001, 7'h3F);
            check($sformatf("midrst_update_e%0d", e), 32'(bus.UPDATE), 32'(e == 4));
        end
        check("midrst_nibble0", 32'(bus.DIGITS[3:0]), 32'h0);

        // Random scanning with occasional resets, glitches and illegal glyphs.
        for (int seg_i = 0; seg_i < 250; seg_i++) begin
            logic [3:0] an;
            logic [6:0] seg;
            int hold, kind;
            kind = int'($urandom_range(0, 9));
            an   = (kind < 7) ? 4'(1 << $urandom_range(0, 3)) : (kind == 7) ? 4'b0000 : 4'($urandom);
            kind = int'($urandom_range(0, 9));
            seg  = (kind < 7) ? lut[$urandom_range(0, 9)] : (kind == 7) ? 7'h00 : 7'($urandom);
            hold = int'($urandom_range(1, 7));
            for (int c = 0; c < hold; c++) step(($urandom_range(0, 59) != 0), an, seg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_to_bcd.md
# seg7_scan_to_bcd

Receive-side counterpart of the BCD-to-7-segment decoder. The block watches a time-multiplexed 4-digit 7-segment display bus (segment lines plus one-hot digit enables) and reconstructs the BCD value shown on each digit. It sits on the observation or loopback side of the display path, for self-check and readback. The block filters scan ghosting by requiring a stable dwell before it captures a digit.

## Interface
Parameters:
- STABLE_CNT, default 4: number of consecutive identical input cycles required to capture a digit; legal values are 2 or more.

Ports:
- CLK  input  1  the single clock; all logic on the rising edge.
- RST_N  input  1  synchronous, active-low reset.
- SEG  input  7  segment lines, active-high. SEG[0]=a, SEG[1]=b, … SEG[6]=g.
- AN  input  4  digit enables, active-high. AN[i] selects digit i.
- DIGITS  output  16  captured BCD values. DIGITS[4i+3:4i] holds digit i; 4'hF means no valid digit.
- VALID  output  4  VALID[i]=1 when digit i holds a legal decoded value.
- ERR  output  4  ERR[i]=1 when the last capture on digit i was an illegal segment pattern.
- UPDATE  output  1  one-cycle pulse on every capture.
- DIGIT_IDX  output  2  index of the most recent capture.

## Operation
- Legal codes, with SEG as {g..a}: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. No alternate glyphs are legal.
- Internal state:
  - Registered previous sample S_Q = {AN, SEG}.
  - Run counter CNT, width $clog2(STABLE_CNT+1), saturating at STABLE_CNT.
- Each edge, with ONEHOT = (AN has exactly one bit set):
  - If ONEHOT and {AN, SEG} equals S_Q: CNT increments, saturating.
  - Else if ONEHOT: CNT loads 1.
  - Else: CNT loads 0. This covers AN=0000, which is the blanking gap, and any multi-hot AN.
  - S_Q always loads the current input.
- Capture condition: ONEHOT, input equals S_Q, and CNT == STABLE_CNT-1.
  - Exactly one capture happens per stable run. Further cycles at saturation do not capture again.
- On capture of digit i:
  - Legal code: DIGITS nibble i gets the value, VALID[i]=1, ERR[i]=0.
  - SEG=00 (blank digit): nibble gets F, VALID[i]=0, ERR[i]=0.
  - Any other pattern: nibble gets F, VALID[i]=0, ERR[i]=1.
  - In all cases UPDATE=1 for that cycle and DIGIT_IDX=i. Other digits are untouched.
- A capture repeating identical contents still pulses UPDATE.

## Timing
- Reset values, applied at the first edge with RST_N=0:
  - DIGITS=16'hFFFF, VALID=0000, ERR=0000, UPDATE=0, DIGIT_IDX=0.
  - CNT=0, S_Q=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: a pattern first present before edge 0 gives CNT=1 at edge 0. Outputs update at edge STABLE_CNT-1, so they reflect the pattern after STABLE_CNT edges of presence.
- UPDATE is high for exactly the one cycle following the capture edge, and low otherwise.
- Any change in SEG or AN mid-run restarts the count at 1. A glitch shorter than STABLE_CNT cycles is never captured.
- Reset during a run discards the run. A full STABLE_CNT-cycle run after RST_N returns high is needed before the next capture.
- RST_N low has priority over a simultaneous capture condition.
- Back-to-back digits with no gap: the new AN value is a mismatch, so CNT=1 on the first cycle of the new digit.

## Test plan
1. Reset: hold RST_N=0 for 2 cycles with arbitrary inputs. Required: DIGITS=FFFF, VALID=0, ERR=0, UPDATE=0. Then apply AN=0001, SEG=06 for 3 cycles with STABLE_CNT=4. Required: no UPDATE.
2. Single capture, STABLE_CNT=4: AN=0001, SEG=5B for 14 cycles. Required at edge 3: DIGITS[3:0]=2, VALID=0001, DIGIT_IDX=0, and one UPDATE pulse. No further UPDATE pulses.
3. Glitch rejection on AN=0100:
   - Apply SEG=4F for 3 cycles, then 7F for 1 cycle, then 4F for 4 cycles.
   - Required: a single capture, DIGITS[11:8]=3.
   - The digit-2 nibble never shows 8.
4. Full scan:
   - Drive AN=1000/0100/0010/0001 with SEG=06/6F/7F/3F.
   - Use an 8-cycle dwell per digit with a 1-cycle AN=0000 gap between digits.
   - Required: DIGITS=16'h1980, VALID=1111, ERR=0000, and 4 UPDATE pulses.
5. Illegal and blank patterns on AN=0010:
   - SEG=49 for 4 cycles. Required: nibble 1=F, VALID[1]=0, ERR[1]=1.
   - Then SEG=00 for 4 cycles. Required: ERR[1]=0, VALID[1]=0, nibble 1=F.
6. Multi-hot AN and reset mid-run:
   - AN=0011, SEG=3F for 20 cycles. Required: no UPDATE.
   - Then AN=0001, SEG=3F; assert RST_N=0 after 2 cycles for 1 cycle. Required: the capture occurs exactly 4 edges after RST_N returns high.
